// File: rtl/tt_mask_idx_rx.sv
// Receive side of the VPU->LSU mask/index credit link: a small FIFO of mask words or
// index items, unpacked into a per-element stream and returning one credit per freed entry.
module tt_mask_idx_rx #(
  parameter int VLEN         = 256,
  parameter int MASK_CREDITS = 2
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_mask_idx_valid,
  input  logic [64:0]                i_mask_idx_item,
  input  logic                       i_mask_idx_last_idx,
  output logic                       o_mask_idx_credit,
  input  logic                       i_memop_sync_start,
  input  logic                       i_memop_sync_end,
  input  logic                       i_is_masked_memop,
  input  logic                       i_is_indexed,
  input  logic [$clog2(VLEN+1)-1:0]  i_vl,
  output logic                       o_elem_valid,
  input  logic                       i_elem_ready,
  output logic                       o_elem_active,
  output logic [63:0]                o_elem_offset,
  output logic [$clog2(VLEN)-1:0]    o_elem_idx,
  output logic                       o_elem_last,
  output logic                       o_busy,
  output logic                       o_err,
  output logic [1:0]                 dbg_state
);
  localparam int VLW = $clog2(VLEN + 1);
  localparam int IW  = $clog2(VLEN);
  localparam int PW  = (MASK_CREDITS > 1) ? $clog2(MASK_CREDITS) : 1;
  localparam int CW  = $clog2(MASK_CREDITS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t          state;
  logic [65:0]     mem [MASK_CREDITS];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [5:0]      bitptr;
  logic [IW-1:0]   elem_idx;
  logic [VLW-1:0]  vl_q;
  logic            masked_q;
  logic            indexed_q;

  logic [65:0]     head;
  logic            empty;
  logic            full;
  logic            xfer;
  logic            pop;
  logic            push;
  logic            overflow;
  logic            is_last;
  logic            active_raw;

  // Entry layout: [65]=last_idx flag, [64]=mask bit, [63:0]=mask word or index.
  assign head     = mem[rd_ptr];
  assign empty    = (count == '0);
  assign full     = (count == CW'(MASK_CREDITS));
  assign is_last  = (VLW'(elem_idx) == (vl_q - VLW'(1)));

  assign o_elem_valid = (state == ACTIVE) && !empty;
  assign xfer         = o_elem_valid && i_elem_ready;

  assign pop = ((state == ACTIVE) && xfer && (indexed_q || (bitptr == 6'd63) || is_last)) ||
               ((state == FLUSH) && !empty);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push     = i_mask_idx_valid && (!full || pop);
  assign overflow = i_mask_idx_valid && full && !pop;

  always_comb begin
    active_raw = 1'b1;
    if (masked_q) begin
      active_raw = indexed_q ? head[64] : head[bitptr];
    end
  end

  assign o_elem_active = o_elem_valid && active_raw;
  assign o_elem_offset = (o_elem_valid && indexed_q) ? head[63:0] : 64'd0;
  assign o_elem_last   = o_elem_valid && is_last;
  assign o_elem_idx    = elem_idx;
  assign o_busy        = (state != IDLE);
  assign dbg_state     = state;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(MASK_CREDITS - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= {i_mask_idx_last_idx, i_mask_idx_item};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state             <= IDLE;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      bitptr            <= '0;
      elem_idx          <= '0;
      vl_q              <= '0;
      masked_q          <= 1'b0;
      indexed_q         <= 1'b0;
      o_mask_idx_credit <= 1'b0;
      o_err             <= 1'b0;
    end else begin
      o_mask_idx_credit <= pop;
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (overflow) o_err <= 1'b1;
      // Sender and receiver disagree on op length when the final index is not flagged.
      if ((state == ACTIVE) && xfer && indexed_q && is_last && !head[65]) o_err <= 1'b1;

      case (state)
        IDLE: begin
          if (i_memop_sync_start && (i_is_masked_memop || i_is_indexed) && (i_vl != '0)) begin
            state     <= ACTIVE;
            masked_q  <= i_is_masked_memop;
            indexed_q <= i_is_indexed;
            vl_q      <= i_vl;
            bitptr    <= '0;
            elem_idx  <= '0;
          end
        end
        ACTIVE: begin
          if (xfer) begin
            elem_idx <= elem_idx + 1'b1;
            bitptr   <= pop ? 6'd0 : bitptr + 6'd1;
          end
          if (xfer && is_last) begin
            state    <= IDLE;
            elem_idx <= '0;
          end else if (i_memop_sync_end) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (empty && !i_mask_idx_valid) begin
            state    <= IDLE;
            elem_idx <= '0;
            bitptr   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tt_mask_idx_rx.sv
// Directed bench for tt_mask_idx_rx: strided/indexed unpacking, backpressure, overflow,
// abort flush and mid-op reset, with an element scoreboard and credit monitor.
module tb_tt_mask_idx_rx;
  logic         clk;
  logic         rst_n;
  logic         mi_valid;
  logic [64:0]  mi_item;
  logic         mi_last;
  logic         credit;
  logic         sync_start;
  logic         sync_end;
  logic         is_masked;
  logic         is_indexed;
  logic [8:0]   vl;
  logic         elem_valid;
  logic         elem_ready;
  logic         elem_active;
  logic [63:0]  elem_offset;
  logic [7:0]   elem_idx;
  logic         elem_last;
  logic         busy;
  logic         err;
  logic [1:0]   dbg_state;

  int checks;
  int failures;
  int credit_cnt;
  int credits_avail;
  int cred0;
  logic [127:0] exp_q[$];

  tt_mask_idx_rx #(.VLEN(256), .MASK_CREDITS(2)) dut (
    .i_clk               (clk),
    .i_reset_n           (rst_n),
    .i_mask_idx_valid    (mi_valid),
    .i_mask_idx_item     (mi_item),
    .i_mask_idx_last_idx (mi_last),
    .o_mask_idx_credit   (credit),
    .i_memop_sync_start  (sync_start),
    .i_memop_sync_end    (sync_end),
    .i_is_masked_memop   (is_masked),
    .i_is_indexed        (is_indexed),
    .i_vl                (vl),
    .o_elem_valid        (elem_valid),
    .i_elem_ready        (elem_ready),
    .o_elem_active       (elem_active),
    .o_elem_offset       (elem_offset),
    .o_elem_idx          (elem_idx),
    .o_elem_last         (elem_last),
    .o_busy              (busy),
    .o_err               (err),
    .dbg_state           (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  function automatic logic [127:0] ep(input logic act, input logic [63:0] off, input int idx,
                                      input logic last);
    return {54'd0, act, off, idx[7:0], last};
  endfunction

  // Scoreboard: every accepted element must match the front of exp_q
  always @(negedge clk) begin
    if (rst_n && elem_valid && elem_ready) begin
      if (exp_q.size() == 0) begin
        check("unexp_elem", {54'd0, elem_active, elem_offset, elem_idx, elem_last}, 128'd0);
      end else begin
        check("elem", {54'd0, elem_active, elem_offset, elem_idx, elem_last}, exp_q.pop_front());
      end
    end
    if (rst_n && credit) begin
      credit_cnt++;
      credits_avail++;
    end
  end

  // Driver tasks: inputs change at posedge+1, outputs are sampled at negedge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic start_op(input logic m, input logic x, input logic [8:0] n);
    sync_start = 1'b1; is_masked = m; is_indexed = x; vl = n;
    tick();
    sync_start = 1'b0;
  endtask

  task automatic send(input logic [64:0] item, input logic last);
    int t;
    t = 0;
    while (credits_avail == 0 && t < 200) begin
      tick();
      t++;
    end
    check("credit_wait", {127'd0, credits_avail > 0}, 128'd1);
    mi_valid = 1'b1; mi_item = item; mi_last = last;
    credits_avail--;
    tick();
    mi_valid = 1'b0; mi_last = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int t;
    t = 0;
    while (busy && t < budget) begin
      tick();
      t++;
    end
    sample();
    check(tag, {127'd0, busy}, 128'd0);
    tick();
    tick();
  endtask

  task automatic wait_drained(input string tag, input int budget);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      tick();
      t++;
    end
    check(tag, exp_q.size(), 128'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    credits_avail = 2;
  endtask

  initial begin
    logic [63:0] w0, w1, w2, w;
    logic [63:0] offs [4];
    checks = 0; failures = 0; credit_cnt = 0; credits_avail = 2;
    rst_n = 1'b0; mi_valid = 1'b0; mi_item = '0; mi_last = 1'b0;
    sync_start = 1'b0; sync_end = 1'b0; is_masked = 1'b0; is_indexed = 1'b0;
    vl = '0; elem_ready = 1'b0;
    tick();
    tick();
    sample();
    check("rst_outs", {elem_valid, elem_active, elem_offset, elem_idx, elem_last, credit, busy, err},
          128'd0);
    check("rst_state", dbg_state, 128'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: strided masked, vl=8, word 0xA5
    cred0 = credit_cnt;
    for (int i = 0; i < 8; i++) exp_q.push_back(ep((8'hA5 >> i) & 1, 64'd0, i, i == 7));
    elem_ready = 1'b1;
    start_op(1'b1, 1'b0, 9'd8);
    mi_valid = 1'b1; mi_item = {1'b0, 64'hA5}; mi_last = 1'b1; credits_avail--;
    sample();
    check("t1_latency0", {127'd0, elem_valid}, 128'd0);
    tick();
    mi_valid = 1'b0; mi_last = 1'b0;
    sample();
    check("t1_latency1", {127'd0, elem_valid}, 128'd1);
    wait_idle("t1_idle", 50);
    check("t1_drained", exp_q.size(), 128'd0);
    check("t1_credits", credit_cnt - cred0, 128'd1);

    // 2: strided masked, vl=130 across three words
    cred0 = credit_cnt;
    w0 = 64'hDEAD_BEEF_0123_4567; w1 = 64'h8000_0000_0000_0001; w2 = 64'h2;
    for (int i = 0; i < 130; i++) begin
      w = (i < 64) ? w0 : (i < 128) ? w1 : w2;
      exp_q.push_back(ep(w[i % 64], 64'd0, i, i == 129));
    end
    start_op(1'b1, 1'b0, 9'd130);
    send({1'b0, w0}, 1'b0);
    send({1'b0, w1}, 1'b0);
    send({1'b0, w2}, 1'b1);
    wait_idle("t2_idle", 400);
    check("t2_drained", exp_q.size(), 128'd0);
    check("t2_credits", credit_cnt - cred0, 128'd3);

    // 3: indexed unmasked, vl=4; mask bits in items ignored
    cred0 = credit_cnt;
    offs[0] = 64'h10; offs[1] = 64'hFFFF_FFFF_FFFF_FFF8; offs[2] = 64'h0; offs[3] = 64'h7FF;
    for (int i = 0; i < 4; i++) exp_q.push_back(ep(1'b1, offs[i], i, i == 3));
    start_op(1'b0, 1'b1, 9'd4);
    for (int i = 0; i < 4; i++) send({i[0], offs[i]}, i == 3);
    wait_idle("t3_idle", 100);
    check("t3_drained", exp_q.size(), 128'd0);
    check("t3_credits", credit_cnt - cred0, 128'd4);
    check("t3_err", {127'd0, err}, 128'd0);

    // 4: backpressure with a full FIFO, then overflow
    elem_ready = 1'b0;
    start_op(1'b1, 1'b1, 9'd3);
    send({1'b1, 64'hAAAA}, 1'b0);
    send({1'b0, 64'hBBBB}, 1'b0);
    cred0 = credit_cnt;
    for (int c = 0; c < 5; c++) begin
      sample();
      check("t4_hold", {54'd0, elem_valid, elem_offset, elem_idx, elem_active},
            {54'd0, 1'b1, 64'hAAAA, 8'd0, 1'b1});
      tick();
    end
    check("t4_nocredit", credit_cnt - cred0, 128'd0);
    mi_valid = 1'b1; mi_item = {1'b1, 64'hCCCC};
    tick();
    mi_valid = 1'b0;
    sample();
    check("t4_err", {127'd0, err}, 128'd1);
    exp_q.push_back(ep(1'b1, 64'hAAAA, 0, 1'b0));
    exp_q.push_back(ep(1'b0, 64'hBBBB, 1, 1'b0));
    tick();
    elem_ready = 1'b1;
    wait_drained("t4_drained", 50);
    tick();
    tick();
    sample();
    check("t4_err_sticky", {127'd0, err}, 128'd1);
    check("t4_credits", credit_cnt - cred0, 128'd2);
    check("t4_busy", {127'd0, busy}, 128'd1);

    // 6: reset mid ACTIVE
    tick();
    rst_n = 1'b0;
    tick();
    sample();
    check("t6_outs", {elem_valid, elem_active, elem_offset, elem_idx, elem_last, credit, busy, err},
          128'd0);
    check("t6_state", dbg_state, 128'd0);
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    credits_avail = 2;
    tick();

    // 5: abort after one of three indexed elements
    cred0 = credit_cnt;
    elem_ready = 1'b0;
    start_op(1'b1, 1'b1, 9'd3);
    send({1'b1, 64'h100}, 1'b0);
    send({1'b1, 64'h200}, 1'b0);
    exp_q.push_back(ep(1'b1, 64'h100, 0, 1'b0));
    elem_ready = 1'b1;
    tick();
    elem_ready = 1'b0;
    sync_end = 1'b1;
    mi_valid = 1'b1; mi_item = {1'b1, 64'h300}; mi_last = 1'b1; credits_avail--;
    tick();
    sync_end = 1'b0; mi_valid = 1'b0; mi_last = 1'b0;
    sample();
    check("t5_flush", dbg_state, 128'd2);
    tick();
    wait_idle("t5_idle", 50);
    check("t5_drained", exp_q.size(), 128'd0);
    check("t5_credits", credit_cnt - cred0, 128'd3);
    check("t5_err", {127'd0, err}, 128'd0);

    // 5b: next op after abort runs normally
    cred0 = credit_cnt;
    elem_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(ep((4'h6 >> i) & 1, 64'd0, i, i == 3));
    start_op(1'b1, 1'b0, 9'd4);
    send({1'b0, 64'h6}, 1'b1);
    wait_idle("t5b_idle", 50);
    check("t5b_drained", exp_q.size(), 128'd0);
    check("t5b_credits", credit_cnt - cred0, 128'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
